decode_stage: RTL

Registered RV32I instruction decode stage: the producer of the `aluOp`/`func` control pair consumed by the execute-stage ALU. It accepts a fetched instruction and PC over a valid/ready handshake and decodes them into ALU controls, register indices, an immediate and datapath controls. Results are held in a single output pipeline register with stall (back-pressure) and flush support. It sits between fetch and execute in the core pipeline.

---
 rtl/decode_stage_if.sv | 31 +++
 rtl/decode_stage.sv | 125 ++++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// Fetch -> decode -> execute handshake bundle for the RV32I decode stage.
// The master side is fetch/execute (the bench); slave is the decode stage.
interface decode_stage_if #(parameter int width = 32);
  logic             inValid;
  logic             inReady;
  logic [31:0]      instr;
  logic [width-1:0] pcIn;
  logic             flush;
  logic             outValid;
  logic             outReady;
  logic [width-1:0] pcOut;
  logic [2:0]       aluOp;
  logic [3:0]       func;
  logic [4:0]       rs1, rs2, rd;
  logic [width-1:0] imm;
  logic [1:0]       aluSrcA;
  logic             aluSrcB;
  logic             regWrite, memRead, memWrite, branch, jump, illegal;

  modport master (
    output inValid, instr, pcIn, flush, outReady,
    input  inReady, outValid, pcOut, aluOp, func, rs1, rs2, rd, imm,
           aluSrcA, aluSrcB, regWrite, memRead, memWrite, branch, jump, illegal
  );

  modport slave (
    input  inValid, instr, pcIn, flush, outReady,
    output inReady, outValid, pcOut, aluOp, func, rs1, rs2, rd, imm,
           aluSrcA, aluSrcB, regWrite, memRead, memWrite, branch, jump, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: one-entry output register with stall and flush.
// Produces aluOp/func for the execute ALU plus register indices, immediate and controls.
module decode_stage #(
  parameter int width = 32
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);
  typedef struct packed {
    logic [width-1:0] pc;
    logic [2:0]       aluOp;
    logic [3:0]       func;
    logic [4:0]       rs1, rs2, rd;
    logic [width-1:0] imm;
    logic [1:0]       aluSrcA;
    logic             aluSrcB;
    logic             regWrite, memRead, memWrite, branch, jump, illegal;
  } bundle_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [31:0]      ins;
  logic [2:0]       f3;
  logic [width-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  bundle_t          d, q;
  logic             valid, take;

  assign ins = bus.instr;
  assign f3  = ins[14:12];

  // Sign extension comes from the signed size cast
  assign imm_i = width'($signed(ins[31:20]));
  assign imm_s = width'($signed({ins[31:25], ins[11:7]}));
  assign imm_b = width'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
  assign imm_u = width'($signed({ins[31:12], 12'b0}));
  assign imm_j = width'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));

  always_comb begin
    d     = '0;
    d.pc  = bus.pcIn;
    d.rs1 = ins[19:15];
    d.rs2 = ins[24:20];
    d.rd  = ins[11:7];
    unique case (ins[6:0])
      OP_R: begin
        d.aluOp = 3'b010; d.func = {ins[30], f3}; d.regWrite = 1'b1;
      end
      OP_I: begin
        // instr[30] only selects SRA vs SRL; for ADDI it is an immediate bit
        d.aluOp = 3'b010; d.func = {(f3 == 3'b101) & ins[30], f3};
        d.aluSrcB = 1'b1; d.regWrite = 1'b1; d.imm = imm_i;
      end
      OP_LOAD: begin
        d.aluSrcB = 1'b1; d.memRead = 1'b1; d.regWrite = 1'b1; d.imm = imm_i;
      end
      OP_STORE: begin
        d.aluSrcB = 1'b1; d.memWrite = 1'b1; d.imm = imm_s;
      end
      OP_BRANCH: begin
        d.aluOp = 3'b001; d.func = {1'b0, f3}; d.branch = 1'b1; d.imm = imm_b;
      end
      OP_LUI: begin
        d.func = {1'b0, f3}; d.aluSrcA = 2'b10; d.aluSrcB = 1'b1;
        d.regWrite = 1'b1; d.imm = imm_u;
      end
      OP_AUIPC: begin
        d.func = {1'b0, f3}; d.aluSrcA = 2'b01; d.aluSrcB = 1'b1;
        d.regWrite = 1'b1; d.imm = imm_u;
      end
      OP_JAL: begin
        d.func = {1'b0, f3}; d.aluSrcA = 2'b01; d.aluSrcB = 1'b1;
        d.jump = 1'b1; d.regWrite = 1'b1; d.imm = imm_j;
      end
      OP_JALR: begin
        d.func = {1'b0, f3}; d.aluSrcB = 1'b1;
        d.jump = 1'b1; d.regWrite = 1'b1; d.imm = imm_i;
      end
      default: d.illegal = 1'b1;
    endcase
  end

  assign bus.inReady = !valid || bus.outReady;
  assign take        = bus.inValid && bus.inReady;

  // Flush beats both load and drain; data may go stale while valid is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (bus.flush) begin
      valid <= 1'b0;
    end else if (take) begin
      valid <= 1'b1;
      q     <= d;
    end else if (bus.outReady) begin
      valid <= 1'b0;
    end
  end

  assign bus.outValid = valid;
  assign bus.pcOut    = q.pc;
  assign bus.aluOp    = q.aluOp;
  assign bus.func     = q.func;
  assign bus.rs1      = q.rs1;
  assign bus.rs2      = q.rs2;
  assign bus.rd       = q.rd;
  assign bus.imm      = q.imm;
  assign bus.aluSrcA  = q.aluSrcA;
  assign bus.aluSrcB  = q.aluSrcB;
  assign bus.regWrite = q.regWrite;
  assign bus.memRead  = q.memRead;
  assign bus.memWrite = q.memWrite;
  assign bus.branch   = q.branch;
  assign bus.jump     = q.jump;
  assign bus.illegal  = q.illegal;
endmodule
